// File: rtl/pixel_kernel_sequencer.sv
// pixel_kernel_sequencer: steps a kernel of pixel FSMs through start, timed settle and done
module pixel_kernel_sequencer #(
    parameter int NPIX   = 4,
    parameter int TW     = 10,
    parameter int WDOG_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [TW-1:0]   loc_max_clk,
    input  logic [TW-1:0]   adj_max_clk,
    output logic [NPIX-1:0] pxl_start_o,
    input  logic [NPIX-1:0] pxl_done_i,
    input  logic [NPIX-1:0] loc_timer_en_i,
    input  logic [NPIX-1:0] adj_timer_en_i,
    output logic [NPIX-1:0] loc_timer_m_o,
    output logic [NPIX-1:0] adj_timer_m_o,
    output logic [3:0]      active_idx_o,
    output logic            busy_o,
    output logic            kernel_done_o,
    output logic            err_timeout_o
);
    typedef enum logic [2:0] {IDLE, START, WAIT, NEXT, DONE} state_t;

    state_t            state;
    logic [3:0]        idx;
    logic [TW-1:0]     loc_max, adj_max, loc_cnt, adj_cnt;
    logic [WDOG_W-1:0] wdog;
    logic [NPIX-1:0]   sel;
    logic              run, done_hit, loc_en, adj_en, loc_hit, adj_hit;

    // active-pixel select; timers only run in WAIT and stop dead on abort
    always_comb begin
        sel      = NPIX'(1) << idx;
        run      = state == WAIT && !abort_i;
        done_hit = |(pxl_done_i & sel);
        loc_en   = run && |(loc_timer_en_i & sel);
        adj_en   = run && |(adj_timer_en_i & sel);
        loc_hit  = loc_en && loc_cnt == loc_max;
        adj_hit  = adj_en && adj_cnt == adj_max;
    end

    // kernel sequencing, per-pixel watchdog and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            idx           <= '0;
            wdog          <= '0;
            loc_max       <= '0;
            adj_max       <= '0;
            err_timeout_o <= 1'b0;
        end else if (abort_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    loc_max       <= loc_max_clk;
                    adj_max       <= adj_max_clk;
                    idx           <= '0;
                    err_timeout_o <= 1'b0;
                    state         <= START;
                end
                START: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wdog <= wdog + WDOG_W'(1);
                    if (done_hit) begin
                        state <= idx == 4'(NPIX - 1) ? DONE : NEXT;
                    end else if (&(wdog + WDOG_W'(1))) begin
                        err_timeout_o <= 1'b1;
                        state         <= DONE;
                    end
                end
                NEXT: begin
                    idx   <= idx + 4'd1;
                    state <= START;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // settle timers restart whenever enable drops; a match emits a one-cycle max pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loc_cnt       <= '0;
            adj_cnt       <= '0;
            loc_timer_m_o <= '0;
            adj_timer_m_o <= '0;
        end else begin
            loc_cnt       <= loc_en && !loc_hit ? loc_cnt + TW'(1) : '0;
            adj_cnt       <= adj_en && !adj_hit ? adj_cnt + TW'(1) : '0;
            loc_timer_m_o <= loc_hit ? sel : '0;
            adj_timer_m_o <= adj_hit ? sel : '0;
        end
    end

    assign pxl_start_o   = state == START ? sel : '0;
    assign active_idx_o  = idx;
    assign busy_o        = state != IDLE;
    assign kernel_done_o = state == DONE;
endmodule

// File: tb/tb_pixel_kernel_sequencer.sv
// tb_pixel_kernel_sequencer: randomized kernels scored against a schedule-level reference model
module tb_pixel_kernel_sequencer;
    localparam int NP   = 4;
    localparam int TWB  = 10;
    localparam int WD   = 5;
    localparam int TO   = (1 << WD) - 1;
    localparam int MAXC = 256;

    typedef struct packed {
        logic [NP-1:0] st;
        logic [NP-1:0] lm;
        logic [NP-1:0] am;
        logic [3:0]    idx;
        logic          busy;
        logic          kd;
        logic          err;
    } obs_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start_i = 1'b0;
    logic           abort_i = 1'b0;
    logic [TWB-1:0] loc_max_clk = '0;
    logic [TWB-1:0] adj_max_clk = '0;
    logic [NP-1:0]  pxl_done_i = '0;
    logic [NP-1:0]  loc_timer_en_i = '0;
    logic [NP-1:0]  adj_timer_en_i = '0;
    logic [NP-1:0]  pxl_start_o, loc_timer_m_o, adj_timer_m_o;
    logic [3:0]     active_idx_o;
    logic           busy_o, kernel_done_o, err_timeout_o;

    int         vectors = 0;
    int         miscompares = 0;
    obs_t       exp_q[$];
    logic [3:0] prev_idx = '0;
    logic       prev_err = 1'b0;

    pixel_kernel_sequencer #(.NPIX(NP), .TW(TWB), .WDOG_W(WD)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start_i(start_i),
        .abort_i(abort_i),
        .loc_max_clk(loc_max_clk),
        .adj_max_clk(adj_max_clk),
        .pxl_start_o(pxl_start_o),
        .pxl_done_i(pxl_done_i),
        .loc_timer_en_i(loc_timer_en_i),
        .adj_timer_en_i(adj_timer_en_i),
        .loc_timer_m_o(loc_timer_m_o),
        .adj_timer_m_o(adj_timer_m_o),
        .active_idx_o(active_idx_o),
        .busy_o(busy_o),
        .kernel_done_o(kernel_done_o),
        .err_timeout_o(err_timeout_o)
    );

    always #5 clk = ~clk;

    function automatic obs_t actual();
        return {pxl_start_o, loc_timer_m_o, adj_timer_m_o, active_idx_o, busy_o, kernel_done_o, err_timeout_o};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s t=%0t: got start=%b locm=%b adjm=%b idx=%0d busy=%b kdone=%b err=%b, expected start=%b locm=%b adjm=%b idx=%0d busy=%b kdone=%b err=%b",
                     name, $time, got.st, got.lm, got.am, got.idx, got.busy, got.kd, got.err,
                     want.st, want.lm, want.am, want.idx, want.busy, want.kd, want.err);
        end
    endtask

    // length of the unbroken enable run of the active pixel ending at cycle c
    function automatic int run_len(input bit en[MAXC], input bit wt[MAXC], input int px[MAXC], input int c);
        int r = 0;
        for (int j = c; j >= 0 && wt[j] && px[j] == px[c] && en[j]; j--) r++;
        return r;
    endfunction

    // monitor: every cycle the bench scheduled is compared at the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) check("cycle", actual(), exp_q.pop_front());
    end

    // kind: 0 normal, 1 abort mid-kernel, 2 watchdog timeout, 3 start+abort in IDLE
    task automatic run_kernel(input int kind, input int fixed_d);
        int   s[NP], w[NP], pix[MAXC];
        bit   le[MAXC], ae[MAXC], wt[MAXC];
        int   npx, kend, a, q, lm, am, gap, r;
        obs_t e;
        lm = fixed_d != 0 ? 3 : $urandom_range(7);
        am = fixed_d != 0 ? 5 : $urandom_range(7);
        q = kind == 2 ? $urandom_range(NP - 1) : NP;
        a = 0;
        npx = NP;
        for (int p = 0; p < NP; p++) begin
            s[p] = p == 0 ? 1 : w[p-1] + 2;
            if (p == q) w[p] = s[p] + TO;
            else if (fixed_d != 0) w[p] = s[p] + fixed_d;
            else w[p] = s[p] + ($urandom_range(7) == 0 ? TO : $urandom_range(12, 1));
            if (p == q) begin
                npx = p + 1;
                break;
            end
        end
        kend = w[npx-1] + 1;
        if (kind == 1) begin
            a = $urandom_range(w[npx-1], 1);
            kend = a;
        end
        if (kind == 3) kend = 0;
        gap = $urandom_range(3, 1);
        for (int c = 0; c <= kend + gap; c++) begin
            pix[c] = 0;
            for (int p = 0; p < npx; p++) if (s[p] <= c) pix[c] = p;
            wt[c] = c >= 1 && c <= kend && s[pix[c]] < c && c <= w[pix[c]];
            le[c] = $urandom_range(3) != 0;
            ae[c] = $urandom_range(3) != 0;
        end
        for (int c = 0; c <= kend + gap; c++) begin
            @(posedge clk);
            #1;
            start_i = c == 0 || (c <= kend && $urandom_range(1) == 1);
            abort_i = (kind == 1 && c == a) || (kind == 3 && c == 0);
            loc_max_clk = c == 0 ? TWB'(lm) : TWB'($urandom);
            adj_max_clk = c == 0 ? TWB'(am) : TWB'($urandom);
            pxl_done_i = NP'($urandom);
            loc_timer_en_i = NP'($urandom);
            adj_timer_en_i = NP'($urandom);
            if (wt[c]) begin
                pxl_done_i[pix[c]] = c == w[pix[c]] && pix[c] != q;
                loc_timer_en_i[pix[c]] = le[c];
                adj_timer_en_i[pix[c]] = ae[c];
            end
            e = '0;
            if (c >= 1 && c <= kend && c == s[pix[c]]) e.st = NP'(1) << pix[c];
            if (c >= 1 && c <= kend && wt[c-1]) begin
                r = run_len(le, wt, pix, c - 1);
                if (r > 0 && r % (lm + 1) == 0) e.lm = NP'(1) << pix[c-1];
                r = run_len(ae, wt, pix, c - 1);
                if (r > 0 && r % (am + 1) == 0) e.am = NP'(1) << pix[c-1];
            end
            e.idx  = (kind == 3 || c == 0) ? prev_idx : 4'(pix[c <= kend ? c : kend]);
            e.busy = c >= 1 && c <= kend;
            e.kd   = (kind == 0 || kind == 2) && c == kend;
            e.err  = (kind == 3 || c == 0) ? prev_err : (kind == 2 && c >= kend);
            exp_q.push_back(e);
        end
        prev_idx = e.idx;
        prev_err = e.err;
    endtask

    initial begin
        obs_t e;
        int   r;
        #2;
        check("reset_state", actual(), '0);
        @(negedge clk);
        reset_n = 1'b1;
        run_kernel(0, 20);
        run_kernel(1, 0);
        run_kernel(2, 0);
        run_kernel(3, 0);
        run_kernel(0, 0);
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(9);
            run_kernel(r < 5 ? 0 : r < 7 ? 1 : r < 9 ? 2 : 3, 0);
        end
        @(posedge clk);
        #1;
        start_i = 1'b1;
        abort_i = 1'b0;
        loc_max_clk = '0;
        adj_max_clk = '0;
        loc_timer_en_i = '1;
        adj_timer_en_i = '0;
        pxl_done_i = '0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        e = '0;
        e.lm = NP'(1);
        e.busy = 1'b1;
        check("pulse_before_reset", actual(), e);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_mid_wait", actual(), '0);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", actual(), '0);
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
